// File: rtl/decade_clock_pkg.sv
// Shared types and BCD helpers for the decade clock time/date editor.
// All arithmetic works on packed BCD so values go straight to the counter's load port.
package decade_clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT0,
        ST_EDIT1,
        ST_EDIT2,
        ST_COMMIT
    } edit_state_e;

    localparam logic [7:0]  HOUR_MAX   = 8'h23;
    localparam logic [7:0]  MINSEC_MAX = 8'h59;
    localparam logic [7:0]  MONTH_MAX  = 8'h12;
    localparam logic [7:0]  BCD_ZERO   = 8'h00;
    localparam logic [7:0]  BCD_ONE    = 8'h01;
    localparam logic [15:0] YEAR_MAX   = 16'h9999;

    // A two-digit decimal number is divisible by 4 iff (2*tens + units) is.
    function automatic logic div4_bcd(input logic [7:0] b);
        logic [4:0] s;
        s = {b[7:4], 1'b0} + {1'b0, b[3:0]};
        return (s[1:0] == 2'b00);
    endfunction

    function automatic logic is_leap_bcd(input logic [15:0] year);
        if (year[7:0] != 8'h00)
            return div4_bcd(year[7:0]);
        else
            return div4_bcd(year[15:8]);
    endfunction

    function automatic logic [7:0] days_in_month_bcd(input logic [7:0] month, input logic [15:0] year);
        case (month)
            8'h02:                      return is_leap_bcd(year) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v >= hi)          return lo;
        if (v[3:0] == 4'h9)   return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        if (v <= lo)          return hi;
        if (v[3:0] == 4'h0)   return {v[7:4] - 4'd1, 4'h9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        if (v == YEAR_MAX) return 16'h0000;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'h9) begin
                    r[i*4 +: 4] = 4'h0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec16(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        if (v == 16'h0000) return YEAR_MAX;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'h0) begin
                    r[i*4 +: 4] = 4'h9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises an active-low raw key, debounces it, and emits a one-cycle pulse
// on each accepted released->pressed transition.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed_pulse
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;
    logic          w_settled;

    assign w_settled = (r_sync[1] != r_stable) && (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_pulse <= w_settled && r_stable;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (w_settled) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pressed_pulse = r_pulse;

endmodule

// File: rtl/time_set_controller.sv
// Key-driven time/date editor: captures live counter values, edits one BCD field at a time,
// then strobes load_valid so the decade counter loads the edited group.
module time_set_controller
    import decade_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_499_999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        butt_increase,
    input  logic        butt_decrease,
    input  logic        butt_change,
    input  logic        sw_mode,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_min,
    input  logic [7:0]  cur_sec,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_month,
    input  logic [15:0] cur_year,
    output logic [7:0]  set_hour,
    output logic [7:0]  set_min,
    output logic [7:0]  set_sec,
    output logic [7:0]  set_day,
    output logic [7:0]  set_month,
    output logic [15:0] set_year,
    output logic        load_valid,
    output logic        load_sel,
    output logic        edit_active,
    output logic [1:0]  field_sel,
    output logic        blink
);

    localparam int            BW         = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES);

    logic w_inc_evt, w_dec_evt, w_chg_evt, w_do_inc, w_do_dec;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .key_n(butt_increase), .pressed_pulse(w_inc_evt));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .rst_n(rst_n), .key_n(butt_decrease), .pressed_pulse(w_dec_evt));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_chg (
        .clk(clk), .rst_n(rst_n), .key_n(butt_change), .pressed_pulse(w_chg_evt));

    // Change wins over inc/dec; inc and dec together cancel.
    assign w_do_inc = w_inc_evt && !w_dec_evt && !w_chg_evt;
    assign w_do_dec = w_dec_evt && !w_inc_evt && !w_chg_evt;

    edit_state_e r_state, w_state_next;
    logic [7:0]  r_hour, r_min, r_sec, r_day, r_month;
    logic [15:0] r_year;
    logic        r_load_sel;
    logic [7:0]  w_hour_n, w_min_n, w_sec_n, w_day_n, w_month_n, w_day_lim;
    logic [15:0] w_year_n;
    logic        w_load_sel_n, w_edit_active;
    logic [BW-1:0] r_blink_cnt;
    logic        r_blink;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        field_sel    = 2'd0;
        case (r_state)
            ST_IDLE:   if (w_chg_evt) w_state_next = ST_EDIT0;
            ST_EDIT0:  if (w_chg_evt) w_state_next = ST_EDIT1;
            ST_EDIT1: begin
                field_sel = 2'd1;
                if (w_chg_evt) w_state_next = ST_EDIT2;
            end
            ST_EDIT2: begin
                field_sel = 2'd2;
                if (w_chg_evt) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign w_edit_active = (r_state != ST_IDLE);
    assign edit_active   = w_edit_active;
    assign load_valid    = (r_state == ST_COMMIT);

    always_comb begin
        w_hour_n     = r_hour;
        w_min_n      = r_min;
        w_sec_n      = r_sec;
        w_day_n      = r_day;
        w_month_n    = r_month;
        w_year_n     = r_year;
        w_load_sel_n = r_load_sel;
        w_day_lim    = days_in_month_bcd(r_month, r_year);
        if (r_state == ST_IDLE && w_chg_evt) begin
            w_hour_n     = cur_hour;
            w_min_n      = cur_min;
            w_sec_n      = cur_sec;
            w_day_n      = cur_day;
            w_month_n    = cur_month;
            w_year_n     = cur_year;
            w_load_sel_n = sw_mode;
        end else if (w_do_inc || w_do_dec) begin
            case (r_state)
                ST_EDIT0: begin
                    if (r_load_sel)
                        w_hour_n = w_do_inc ? bcd_inc(r_hour, BCD_ZERO, HOUR_MAX)
                                            : bcd_dec(r_hour, BCD_ZERO, HOUR_MAX);
                    else
                        w_day_n  = w_do_inc ? bcd_inc(r_day, BCD_ONE, w_day_lim)
                                            : bcd_dec(r_day, BCD_ONE, w_day_lim);
                end
                ST_EDIT1: begin
                    if (r_load_sel) begin
                        w_min_n = w_do_inc ? bcd_inc(r_min, BCD_ZERO, MINSEC_MAX)
                                           : bcd_dec(r_min, BCD_ZERO, MINSEC_MAX);
                    end else begin
                        w_month_n = w_do_inc ? bcd_inc(r_month, BCD_ONE, MONTH_MAX)
                                             : bcd_dec(r_month, BCD_ONE, MONTH_MAX);
                        w_day_lim = days_in_month_bcd(w_month_n, r_year);
                        if (r_day > w_day_lim) w_day_n = w_day_lim;
                    end
                end
                ST_EDIT2: begin
                    if (r_load_sel) begin
                        w_sec_n = w_do_inc ? bcd_inc(r_sec, BCD_ZERO, MINSEC_MAX)
                                           : bcd_dec(r_sec, BCD_ZERO, MINSEC_MAX);
                    end else begin
                        w_year_n  = w_do_inc ? bcd_inc16(r_year) : bcd_dec16(r_year);
                        w_day_lim = days_in_month_bcd(r_month, w_year_n);
                        if (r_day > w_day_lim) w_day_n = w_day_lim;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hour     <= 8'h00;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_day      <= 8'h01;
            r_month    <= 8'h01;
            r_year     <= 16'h2024;
            r_load_sel <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hour     <= w_hour_n;
            r_min      <= w_min_n;
            r_sec      <= w_sec_n;
            r_day      <= w_day_n;
            r_month    <= w_month_n;
            r_year     <= w_year_n;
            r_load_sel <= w_load_sel_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (!w_edit_active) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= !r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign set_hour  = r_hour;
    assign set_min   = r_min;
    assign set_sec   = r_sec;
    assign set_day   = r_day;
    assign set_month = r_month;
    assign set_year  = r_year;
    assign load_sel  = r_load_sel;
    assign blink     = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed key sequences, a queue of expected load
// strobes, and an independent monitor that checks every load_valid against the queue.
module tb_time_set_controller;

    typedef struct packed {
        logic        sel;
        logic [7:0]  hour, min, sec, day, month;
        logic [15:0] year;
    } load_t;

    localparam logic [2:0] K_INC = 3'b001, K_DEC = 3'b010, K_CHG = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  keys_n;
    logic        sw_mode;
    logic [7:0]  cur_hour, cur_min, cur_sec, cur_day, cur_month;
    logic [15:0] cur_year;
    logic [7:0]  set_hour, set_min, set_sec, set_day, set_month;
    logic [15:0] set_year;
    logic        load_valid, load_sel, edit_active, blink;
    logic [1:0]  field_sel;

    int    checks = 0;
    int    errors = 0;
    load_t exp_q[$];
    load_t mon_act, mon_exp;

    time_set_controller #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .butt_increase(keys_n[0]), .butt_decrease(keys_n[1]), .butt_change(keys_n[2]),
        .sw_mode(sw_mode),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .load_valid(load_valid), .load_sel(load_sel), .edit_active(edit_active),
        .field_sel(field_sel), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    function automatic load_t mk(input logic s, input logic [7:0] h, m, sc, d, mo, input logic [15:0] y);
        return {s, h, m, sc, d, mo, y};
    endfunction

    // Hold the masked keys long enough for one debounced event, then release and settle.
    task automatic press(input logic [2:0] mask);
        @(negedge clk);
        keys_n = ~mask;
        repeat (10) @(posedge clk);
        @(negedge clk);
        keys_n = 3'b111;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cur(input logic [7:0] h, m, s, d, mo, input logic [15:0] y);
        cur_hour = h; cur_min = m; cur_sec = s;
        cur_day = d; cur_month = mo; cur_year = y;
    endtask

    always @(negedge clk) begin
        if (rst_n && load_valid) begin
            mon_act = {load_sel, set_hour, set_min, set_sec, set_day, set_month, set_year};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: got %h, required no load", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL load_value: got %h, required %h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_blink;
        keys_n  = 3'b111;
        sw_mode = 1'b1;
        rst_n   = 1'b0;
        set_cur(8'h23, 8'h59, 8'h58, 8'h15, 8'h06, 16'h2022);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_day",    32'(set_day),     32'h01);
        check("rst_month",  32'(set_month),   32'h01);
        check("rst_year",   32'(set_year),    32'h2024);
        check("rst_hour",   32'(set_hour),    32'h00);
        check("rst_active", 32'(edit_active), 32'h0);
        check("rst_load",   32'(load_valid),  32'h0);
        check("rst_blink",  32'(blink),       32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 1. bounce rejection, then a long hold gives exactly one event
        @(negedge clk); keys_n[2] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); keys_n[2] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bounce_ignored", 32'(edit_active), 32'h0);
        keys_n[2] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("hold_active", 32'(edit_active), 32'h1);
        check("hold_field0", 32'(field_sel),   32'h0);
        check("capture_min", 32'(set_min),     32'h59);
        seen_blink = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_blink |= blink;
        end
        check("blink_toggles", 32'(seen_blink), 32'h1);
        keys_n[2] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("single_event", 32'(field_sel), 32'h0);

        // 2. clock edit; sw_mode flips mid-edit and must be ignored
        sw_mode = 1'b0;
        press(K_INC); check("hour_wrap", 32'(set_hour), 32'h00);
        press(K_CHG); check("field1",    32'(field_sel), 32'h1);
        press(K_DEC); check("min_dec",   32'(set_min),  32'h58);
        press(K_CHG); check("field2",    32'(field_sel), 32'h2);
        exp_q.push_back(mk(1'b1, 8'h00, 8'h58, 8'h58, 8'h15, 8'h06, 16'h2022));
        press(K_CHG);
        check("commit_idle", 32'(edit_active), 32'h0);
        check("idle_blink",  32'(blink),       32'h0);

        // 3. calendar edit with day clamp, then day wrap in a leap February
        set_cur(8'h23, 8'h59, 8'h58, 8'h31, 8'h01, 16'h2023);
        press(K_CHG); press(K_CHG);
        press(K_INC);
        check("month_inc",  32'(set_month), 32'h02);
        check("day_clamp",  32'(set_day),   32'h28);
        press(K_CHG); press(K_INC);
        check("year_inc",   32'(set_year),  32'h2024);
        exp_q.push_back(mk(1'b0, 8'h23, 8'h59, 8'h58, 8'h28, 8'h02, 16'h2024));
        press(K_CHG);
        set_cur(8'h23, 8'h59, 8'h58, 8'h29, 8'h02, 16'h2024);
        press(K_CHG);
        press(K_INC); check("day_wrap_up", 32'(set_day), 32'h01);
        press(K_DEC); check("day_wrap_dn", 32'(set_day), 32'h29);
        exp_q.push_back(mk(1'b0, 8'h23, 8'h59, 8'h58, 8'h29, 8'h02, 16'h2024));
        press(K_CHG); press(K_CHG); press(K_CHG);

        // 4. century leap rules, year wrap, clamp on year change
        set_cur(8'h23, 8'h59, 8'h58, 8'h01, 8'h02, 16'h1900);
        press(K_CHG); press(K_DEC);
        check("feb_1900", 32'(set_day), 32'h28);
        exp_q.push_back(mk(1'b0, 8'h23, 8'h59, 8'h58, 8'h28, 8'h02, 16'h1900));
        press(K_CHG); press(K_CHG); press(K_CHG);
        set_cur(8'h23, 8'h59, 8'h58, 8'h01, 8'h02, 16'h2000);
        press(K_CHG); press(K_DEC);
        check("feb_2000", 32'(set_day), 32'h29);
        exp_q.push_back(mk(1'b0, 8'h23, 8'h59, 8'h58, 8'h29, 8'h02, 16'h2000));
        press(K_CHG); press(K_CHG); press(K_CHG);
        set_cur(8'h23, 8'h59, 8'h58, 8'h31, 8'h01, 16'h9999);
        press(K_CHG); press(K_CHG); press(K_CHG); press(K_INC);
        check("year_wrap", 32'(set_year), 32'h0000);
        exp_q.push_back(mk(1'b0, 8'h23, 8'h59, 8'h58, 8'h31, 8'h01, 16'h0000));
        press(K_CHG);
        set_cur(8'h23, 8'h59, 8'h58, 8'h29, 8'h02, 16'h2024);
        press(K_CHG); press(K_CHG); press(K_CHG); press(K_DEC);
        check("year_dec",       32'(set_year), 32'h2023);
        check("year_day_clamp", 32'(set_day),  32'h28);
        exp_q.push_back(mk(1'b0, 8'h23, 8'h59, 8'h58, 8'h28, 8'h02, 16'h2023));
        press(K_CHG);

        // 5. simultaneous keys
        sw_mode = 1'b1;
        set_cur(8'h12, 8'h30, 8'h45, 8'h29, 8'h02, 16'h2024);
        press(K_CHG);
        press(K_CHG | K_INC);
        check("chg_inc_field", 32'(field_sel), 32'h1);
        check("chg_inc_hour",  32'(set_hour),  32'h12);
        press(K_INC | K_DEC);
        check("inc_dec_min",   32'(set_min),   32'h30);
        press(K_CHG);
        exp_q.push_back(mk(1'b1, 8'h12, 8'h30, 8'h45, 8'h29, 8'h02, 16'h2024));
        press(K_CHG);
        press(K_INC);
        check("idle_inc_ignored", 32'(set_hour), 32'h12);
        check("idle_inc_state",   32'(edit_active), 32'h0);

        // 6. reset in EDIT2
        sw_mode = 1'b0;
        press(K_CHG); press(K_CHG); press(K_CHG);
        check("pre_rst_field", 32'(field_sel), 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_active", 32'(edit_active), 32'h0);
        check("midrst_load",   32'(load_valid),  32'h0);
        check("midrst_year",   32'(set_year),    32'h2024);
        check("midrst_day",    32'(set_day),     32'h01);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", 32'(edit_active), 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
